down_counter: RTL and testbench
===============================

// Module: down_counter
//
// PURPOSE
//   Loadable, programmable down-counter/timer. It is the counting-down counterpart of the
//   free-running up counter used in the simulation examples.
//   Loaded with a start value, it decrements once per enabled clock to zero and flags
//   terminal count with a one-cycle done pulse. It can optionally auto-reload to run as a
//   periodic tick generator. Sits beside the up counter as a timebase/timeout block for
//   example designs.
//
// PARAMETERS
//   N            8      counter width in bits; load values 0 .. 2**N-1
//
// PORTS
//   clock        in   1  single clock, all logic on posedge
//   reset_n      in   1  synchronous, active-low reset
//   start        in   1  load load_value and begin counting (priority over stop/enable)
//   stop         in   1  abort run: return to IDLE, no done pulse
//   enable       in   1  count qualifier; cnt decrements only when 1
//   auto_reload  in   1  1: periodic mode, 0: one-shot
//   load_value   in   N  start/reload value, captured on start
//   cnt          out  N  current count
//   busy         out  1  1 while in RUN
//   done         out  1  one-cycle pulse when cnt reaches 0 from RUN
//
// BEHAVIOUR
//   - Reset: reset_n=0 at posedge -> cnt=0, busy=0, done=0, reload_reg=0, state IDLE.
//     Applies in any state, including mid-run.
//   - All outputs are registered. done defaults to 0 every cycle unless set below.
//   - States: IDLE (busy=0), RUN (busy=1).
//   - Priority each posedge (reset_n=1): start > stop > enable.
//   - start=1, load_value!=0, any state: cnt<=load_value, reload_reg<=load_value,
//     state RUN. Counting begins on the next clock.
//   - start=1, load_value==0: cnt<=0, state IDLE, done<=1 (immediate expiry).
//   - stop=1 (start=0): state IDLE, cnt holds its value, done stays 0.
//   - RUN, enable=0: cnt holds; done=0.
//   - RUN, enable=1, cnt>1: cnt<=cnt-1.
//   - RUN, enable=1, cnt==1: cnt<=0, done<=1 on the same edge.
//     * One-shot (auto_reload=0): state IDLE; busy falls on that edge.
//     * Periodic (auto_reload=1): stays RUN.
//   - RUN, enable=1, cnt==0 (periodic only): cnt<=reload_reg.
//     Period = load_value+1 enabled cycles, one done pulse per period.
//   - auto_reload is sampled at the cnt==1 step. Clearing it mid-run ends the run at the
//     next terminal count.
//   - IDLE, no start: cnt holds, done=0; enable/stop ignored.
//   - Width: decrement is modulo 2**N but never wraps below 0 (0 is terminal).
//     load_value=2**N-1 is legal.
//
// TESTING
//   1 reset_n=0 for 2 clocks, other inputs random -> cnt=0, busy=0, done=0;
//     reset_n=0 mid-run (cnt=5) -> same values next edge.
//   2 N=4, start with load_value=3, enable=1, auto_reload=0 -> cnt 3,2,1,0 on successive
//     edges; done=1 only in the cycle cnt=0; busy 1->0 on the same edge; cnt stays 0.
//   3 auto_reload=1, load_value=2, enable=1 -> cnt 2,1,0,2,1,0,...;
//     done high once every 3 cycles, busy constantly 1.
//   4 load_value=5, enable pattern 1,0,0,1 -> cnt 5,4,4,4,3; no done.
//   5 run at cnt=6: start with load_value=9 -> cnt=9, busy=1;
//     then stop at cnt=7 -> busy=0, cnt held at 7, no done ever.
//   6 start with load_value=0 -> done pulse 1 cycle, busy=0, cnt=0;
//     start and stop asserted together with load_value=4 -> RUN, cnt=4.

Source files
------------

// File: rtl/down_counter.sv
// ============================================================================
//  down_counter : loadable down-counter/timer with one-shot or periodic reload
//  Rev 1.0
// ============================================================================
`default_nettype none

module down_counter #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic         enable,
  input  logic         auto_reload,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] cnt,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] C_ZERO = '0;
  localparam logic [N-1:0] C_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q, done_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= C_ZERO;
      reload_q <= C_ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (start) begin
      cnt_d = load_value;
      if (load_value == C_ZERO) begin
        // Zero load expires immediately without entering RUN.
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        reload_d = load_value;
        state_d  = RUN;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (state_q == RUN && enable) begin
      if (cnt_q == C_ONE) begin
        cnt_d  = C_ZERO;
        done_d = 1'b1;
        if (!auto_reload) begin
          state_d = IDLE;
        end
      end else if (cnt_q == C_ZERO) begin
        // Only reachable in periodic mode: the extra cycle at zero completes the period.
        cnt_d = reload_q;
      end else begin
        cnt_d = cnt_q - C_ONE;
      end
    end
  end

  assign cnt  = cnt_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
// ============================================================================
//  tb_down_counter : directed self-checking bench for down_counter (N=4)
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_down_counter;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic         stop;
  logic         enable;
  logic         auto_reload;
  logic [N-1:0] load_value;
  logic [N-1:0] cnt;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  down_counter #(.N(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .enable      (enable),
    .auto_reload (auto_reload),
    .load_value  (load_value),
    .cnt         (cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int c, input int b, input int d);
    chk({tag, ".cnt"},  int'(cnt),  c);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".done"}, int'(done), d);
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'($urandom_range(0, 1));
    stop        = 1'($urandom_range(0, 1));
    enable      = 1'($urandom_range(0, 1));
    auto_reload = 1'($urandom_range(0, 1));
    load_value  = 4'($urandom_range(0, 15));
    step();
    chk3("rst1", 0, 0, 0);
    start = 1'b1; load_value = 4'd7;
    step();
    chk3("rst2", 0, 0, 0);

    // one-shot count from 3
    reset_n = 1'b1; start = 1'b1; stop = 1'b0; enable = 1'b1;
    auto_reload = 1'b0; load_value = 4'd3;
    step(); chk3("os_load", 3, 1, 0);
    start = 1'b0;
    step(); chk3("os_2", 2, 1, 0);
    step(); chk3("os_1", 1, 1, 0);
    step(); chk3("os_0", 0, 0, 1);
    step(); chk3("os_hold", 0, 0, 0);
    step(); chk3("os_idle", 0, 0, 0);

    // periodic with load 2: period 3
    start = 1'b1; auto_reload = 1'b1; load_value = 4'd2;
    step(); chk3("per_load", 2, 1, 0);
    start = 1'b0;
    step(); chk3("per_1a", 1, 1, 0);
    step(); chk3("per_0a", 0, 1, 1);
    step(); chk3("per_2b", 2, 1, 0);
    step(); chk3("per_1b", 1, 1, 0);
    step(); chk3("per_0b", 0, 1, 1);
    step(); chk3("per_2c", 2, 1, 0);

    // clearing auto_reload ends the run at the next terminal count
    start = 1'b1; load_value = 4'd1;
    step(); chk3("ar_load", 1, 1, 0);
    start = 1'b0;
    step(); chk3("ar_0a", 0, 1, 1);
    step(); chk3("ar_1", 1, 1, 0);
    auto_reload = 1'b0;
    step(); chk3("ar_end", 0, 0, 1);

    // enable gating
    start = 1'b1; load_value = 4'd5;
    step(); chk3("en_load", 5, 1, 0);
    start = 1'b0; enable = 1'b1;
    step(); chk3("en_1", 4, 1, 0);
    enable = 1'b0;
    step(); chk3("en_0a", 4, 1, 0);
    step(); chk3("en_0b", 4, 1, 0);
    enable = 1'b1;
    step(); chk3("en_1b", 3, 1, 0);

    // restart mid-run, then stop
    start = 1'b1; load_value = 4'd8;
    step(); chk3("rs_load", 8, 1, 0);
    start = 1'b0;
    step(); step(); chk3("rs_6", 6, 1, 0);
    start = 1'b1; load_value = 4'd9;
    step(); chk3("rs_9", 9, 1, 0);
    start = 1'b0;
    step(); step(); chk3("rs_7", 7, 1, 0);
    stop = 1'b1;
    step(); chk3("stop", 7, 0, 0);
    stop = 1'b0;
    step(); chk3("stop_idle", 7, 0, 0);

    // reset mid-run
    start = 1'b1; load_value = 4'd5;
    step(); chk3("mr_load", 5, 1, 0);
    start = 1'b0; reset_n = 1'b0;
    step(); chk3("mr_rst", 0, 0, 0);
    reset_n = 1'b1;

    // zero load and start+stop together
    start = 1'b1; load_value = 4'd0;
    step(); chk3("z_load", 0, 0, 1);
    start = 1'b0;
    step(); chk3("z_after", 0, 0, 0);
    start = 1'b1; stop = 1'b1; load_value = 4'd4;
    step(); chk3("ss", 4, 1, 0);
    start = 1'b0; stop = 1'b0;

    // full-scale load value
    start = 1'b1; load_value = 4'd15;
    step(); chk3("max_load", 15, 1, 0);
    start = 1'b0;
    step(); chk3("max_dec", 14, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
